// File: rtl/tile_scheduler_if.sv
// Mux-select encoding shared with the PE array, plus the job/array-control
// bundle that connects the tile scheduler to its controller and the array.
package tile_scheduler_pkg;
  parameter int N = 4;

  typedef enum logic [1:0] {
    MUX_PASSTHROUGH = 2'd0,
    MUX_LOAD        = 2'd1,
    MUX_PROCESS     = 2'd2
  } input_mux_t;
endpackage

interface tile_scheduler_if #(
  parameter int N   = tile_scheduler_pkg::N,
  parameter int M_W = 8,
  parameter int K_W = 4
) ();
  logic                            start_i;
  logic [M_W-1:0]                  m_rows_i;
  logic [K_W-1:0]                  k_tiles_i;
  logic                            ready_i;
  logic                            busy_o;
  logic                            done_o;
  tile_scheduler_pkg::input_mux_t  mux_o [N][N];
  logic                            add_zero_o [N][N];
  logic [N-1:0]                    acc_valid_o;
  logic                            acc_clear_o;
  logic [K_W-1:0]                  tile_idx_o;

  // Master is the job controller side; slave is the scheduler itself.
  modport master (
    output start_i, m_rows_i, k_tiles_i, ready_i,
    input  busy_o, done_o, mux_o, add_zero_o, acc_valid_o, acc_clear_o, tile_idx_o
  );

  modport slave (
    input  start_i, m_rows_i, k_tiles_i, ready_i,
    output busy_o, done_o, mux_o, add_zero_o, acc_valid_o, acc_clear_o, tile_idx_o
  );
endinterface

// File: rtl/tile_scheduler.sv
// Sequences weight-tile load and row streaming through an NxN systolic array,
// one tile at a time, and flags when each column's results reach the bottom.
module tile_scheduler #(
  parameter int N   = tile_scheduler_pkg::N,
  parameter int M_W = 8,
  parameter int K_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  tile_scheduler_if.slave   bus
);

  // Wide enough to hold M + 2N - 2 for the largest M without wrapping.
  localparam int CNT_W = M_W + $clog2(2 * N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_LOAD,
    S_PROC,
    S_DONE
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [CNT_W-1:0] cnt;
  logic [K_W-1:0]  tile_idx;
  logic [M_W-1:0]  m_q;
  logic [K_W-1:0]  k_q;

  logic            load_last;
  logic            proc_last;
  logic            more_tiles;
  logic            job_empty;

  tile_scheduler_pkg::input_mux_t mux [N][N];
  logic            add_zero [N][N];
  logic [N-1:0]    acc_valid;
  logic            busy;
  logic            done;

  assign load_last  = (cnt == CNT_W'(N - 1));
  assign proc_last  = (cnt == CNT_W'(m_q) + CNT_W'(2 * N - 2));
  assign more_tiles = (tile_idx < k_q - K_W'(1));
  assign job_empty  = (bus.m_rows_i == '0) || (bus.k_tiles_i == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (bus.start_i) begin
          next_state = job_empty ? S_DONE : S_ARM;
        end
      end
      S_ARM: begin
        if (bus.ready_i) begin
          next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        if (load_last) begin
          next_state = S_PROC;
        end
      end
      S_PROC: begin
        if (proc_last) begin
          next_state = more_tiles ? S_ARM : S_DONE;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Phase counter restarts at 0 on every entry to LOAD or PROC.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt      <= '0;
      tile_idx <= '0;
      m_q      <= '0;
      k_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (bus.start_i) begin
            m_q      <= bus.m_rows_i;
            k_q      <= bus.k_tiles_i;
            tile_idx <= '0;
          end
        end
        S_LOAD: begin
          cnt <= (next_state == S_LOAD) ? cnt + CNT_W'(1) : '0;
        end
        S_PROC: begin
          cnt <= (next_state == S_PROC) ? cnt + CNT_W'(1) : '0;
          if (next_state == S_ARM) begin
            tile_idx <= tile_idx + K_W'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        mux[r][c]      = tile_scheduler_pkg::MUX_PASSTHROUGH;
        add_zero[r][c] = 1'b0;
      end
    end
    acc_valid = '0;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    case (state)
      S_LOAD: begin
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++) begin
            mux[r][c] = load_last ? tile_scheduler_pkg::MUX_LOAD
                                  : tile_scheduler_pkg::MUX_PASSTHROUGH;
          end
        end
      end
      S_PROC: begin
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++) begin
            mux[r][c]      = tile_scheduler_pkg::MUX_PROCESS;
            add_zero[r][c] = (r == 0);
          end
        end
        // Column j's first result emerges N+j cycles in and lasts M cycles.
        for (int j = 0; j < N; j++) begin
          acc_valid[j] = (cnt >= CNT_W'(N + j)) &&
                         (cnt <  CNT_W'(N + j) + CNT_W'(m_q));
        end
      end
      default: ;
    endcase
  end

  assign bus.mux_o       = mux;
  assign bus.add_zero_o  = add_zero;
  assign bus.acc_valid_o = acc_valid;
  assign bus.acc_clear_o = (|acc_valid) && (tile_idx == '0);
  assign bus.busy_o      = busy;
  assign bus.done_o      = done;
  assign bus.tile_idx_o  = tile_idx;

endmodule

// File: tb/tb_tile_scheduler.sv
// Directed and randomized jobs for tile_scheduler, checked cycle by cycle
// against a phase-level timeline model built from the job parameters.
module tb_tile_scheduler;

  localparam int N       = 4;
  localparam int M_W     = 8;
  localparam int K_W     = 4;
  localparam int SW      = 2 + K_W + 2 * N * N + N * N + N + 1;
  localparam int RDY_LEN = 4096;

  typedef logic [SW-1:0] snap_t;

  logic clk;
  logic rst;

  tile_scheduler_if #(.N(N), .M_W(M_W), .K_W(K_W)) bus ();

  tile_scheduler #(.N(N), .M_W(M_W), .K_W(K_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    vecCount  = 0;
  int    missCount = 0;
  int    pulseCnt [N];
  int    doneCnt;
  bit    rdy [RDY_LEN];
  snap_t expQ [$];

  function automatic snap_t expSnap(input bit busy, input bit done, input int tile,
                                    input logic [1:0] mux, input bit az,
                                    input logic [N-1:0] av, input bit clr);
    logic [2*N*N-1:0] mb;
    logic [N*N-1:0]   zb;
    for (int i = 0; i < N * N; i++) begin
      mb[2*i +: 2] = mux;
      zb[i]        = az && (i < N);
    end
    return {busy, done, K_W'(tile), mb, zb, av, clr};
  endfunction

  function automatic snap_t obsSnap();
    logic [2*N*N-1:0] mb;
    logic [N*N-1:0]   zb;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        mb[2*(r*N+c) +: 2] = bus.mux_o[r][c];
        zb[r*N+c]          = bus.add_zero_o[r][c];
      end
    end
    return {bus.busy_o, bus.done_o, bus.tile_idx_o, mb, zb, bus.acc_valid_o, bus.acc_clear_o};
  endfunction

  function automatic void fillReady(input int mode);
    for (int c = 0; c < RDY_LEN; c++) begin
      rdy[c] = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  endfunction

  // Timeline: per tile, ARM until ready is seen, N load cycles, M+2N-1 stream cycles.
  task automatic buildModel(input int m, input int k, output int proc5Idx);
    int          c;
    bit          go;
    logic [N-1:0] av;
    int          lastTile;
    expQ.delete();
    proc5Idx = -1;
    c = 1;
    if (m != 0 && k != 0) begin
      for (int t = 0; t < k; t++) begin
        do begin
          expQ.push_back(expSnap(1, 0, t, tile_scheduler_pkg::MUX_PASSTHROUGH, 0, '0, 0));
          if (c >= RDY_LEN - 2) rdy[c] = 1'b1;
          go = rdy[c];
          c++;
        end while (!go);
        for (int i = 0; i < N; i++) begin
          expQ.push_back(expSnap(1, 0, t, (i == N - 1) ? tile_scheduler_pkg::MUX_LOAD
                                                       : tile_scheduler_pkg::MUX_PASSTHROUGH,
                                 0, '0, 0));
          c++;
        end
        for (int p = 0; p < m + 2 * N - 1; p++) begin
          for (int j = 0; j < N; j++) av[j] = (p >= N + j) && (p < N + j + m);
          expQ.push_back(expSnap(1, 0, t, tile_scheduler_pkg::MUX_PROCESS, 1, av,
                                 (t == 0) && (av != '0)));
          if (t == 0 && p == 5) proc5Idx = expQ.size() - 1;
          c++;
        end
      end
    end
    lastTile = (m == 0 || k == 0) ? 0 : k - 1;
    expQ.push_back(expSnap(1, 1, lastTile, tile_scheduler_pkg::MUX_PASSTHROUGH, 0, '0, 0));
    expQ.push_back(expSnap(0, 0, lastTile, tile_scheduler_pkg::MUX_PASSTHROUGH, 0, '0, 0));
  endtask

  task automatic checkOutput(input snap_t expected, input string tag);
    snap_t observed;
    observed = obsSnap();
    for (int j = 0; j < N; j++) pulseCnt[j] += int'(bus.acc_valid_o[j]);
    doneCnt += int'(bus.done_o);
    vecCount++;
    assert (observed === expected)
      else begin
        missCount++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic checkCount(input int observed, input int expected, input string tag);
    vecCount++;
    assert (observed === expected)
      else begin
        missCount++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input int m, input int k, input bit noise, input bit abort);
    int    proc5Idx;
    snap_t zeroSnap;
    zeroSnap = expSnap(0, 0, 0, tile_scheduler_pkg::MUX_PASSTHROUGH, 0, '0, 0);
    buildModel(m, k, proc5Idx);
    for (int j = 0; j < N; j++) pulseCnt[j] = 0;
    doneCnt = 0;
    $display("[TB] job M=%0d K=%0d noise=%0d abort=%0d", m, k, noise, abort);
    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.m_rows_i  = M_W'(m);
    bus.k_tiles_i = K_W'(k);
    bus.ready_i   = rdy[0];
    for (int idx = 0; idx < expQ.size(); idx++) begin
      @(negedge clk);
      checkOutput(expQ[idx], $sformatf("job M%0d K%0d cycle %0d", m, k, idx + 1));
      bus.ready_i   = (idx + 1 < RDY_LEN) ? rdy[idx + 1] : 1'b1;
      bus.start_i   = (noise && idx < expQ.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.m_rows_i  = M_W'($urandom);
      bus.k_tiles_i = K_W'($urandom);
      if (abort && idx == proc5Idx) begin
        rst         = 1'b1;
        bus.start_i = 1'b0;
        @(negedge clk);
        checkOutput(zeroSnap, "reset mid PROC");
        rst = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checkOutput(zeroSnap, "idle after abort");
        end
        checkCount(doneCnt, 0, "done pulses after abort");
        return;
      end
    end
    for (int j = 0; j < N; j++) begin
      checkCount(pulseCnt[j], m * k, $sformatf("acc_valid[%0d] pulses", j));
    end
    checkCount(doneCnt, 1, "done pulses");
  endtask

  initial begin
    int m;
    int k;
    int armStart;
    rst           = 1'b1;
    bus.start_i   = 1'b0;
    bus.m_rows_i  = '0;
    bus.k_tiles_i = '0;
    bus.ready_i   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput(expSnap(0, 0, 0, tile_scheduler_pkg::MUX_PASSTHROUGH, 0, '0, 0), "reset state");
    rst = 1'b0;

    fillReady(0);
    applyStimulus(5, 0, 1'b0, 1'b0);
    applyStimulus(0, 2, 1'b0, 1'b0);

    fillReady(0);
    applyStimulus(3, 1, 1'b0, 1'b0);

    // Second ARM begins after ARM, N load and M+2N-1 stream cycles of tile 0.
    fillReady(0);
    armStart = 2 + N + 2 + 2 * N - 1;
    for (int c = armStart; c < armStart + 5; c++) rdy[c] = 1'b0;
    applyStimulus(2, 3, 1'b0, 1'b0);

    fillReady(1);
    applyStimulus(4, 2, 1'b0, 1'b1);
    fillReady(0);
    applyStimulus(3, 2, 1'b0, 1'b0);

    fillReady(1);
    applyStimulus(6, 2, 1'b1, 1'b0);

    for (int n = 0; n < 6; n++) begin
      m = $urandom_range(1, 20);
      k = $urandom_range(1, 4);
      fillReady(1);
      applyStimulus(m, k, 1'b1, 1'b0);
    end

    fillReady(0);
    applyStimulus(255, 1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
